mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences one shared single-port unified memory between two requesters: the instruction-fetch stage (IF, read only) and the data-memory stage (DM, read/write).
- Sits between the pipeline's fetch and MEM stages and the memory model.
- Keeps at most one memory transaction outstanding.
- Gives DM priority, with a bounded-starvation guarantee for IF.
- Supports fetch abort on pipeline flush.
- Produces per-port stall signals that the hazard logic uses to freeze PC, IF/ID and EX/MEM.

Parameters:
- ADDR_W, 10, word-address width (byte address bits [11:2])
- DATA_W, 32, data width
- IF_STARVE_MAX, 4, consecutive DM grants allowed while IF is waiting (legal range ≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch word address
- if_abort  in  1  pipeline flush; discard the in-flight or pending fetch
- if_rdata  out  DATA_W  fetched instruction, valid while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_ack
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1=write, 0=read
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data, valid while dm_ack=1
- dm_ack  out  1  one-cycle data completion pulse
- dm_stall  out  1  dm_req & ~dm_ack
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state=IDLE
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0
  - starve_cnt=0, abort_pend=0
  - Reset mid-transaction drops it silently; the memory side is reset by the same rst.
- FSM states: IDLE, IF_BUSY, DM_BUSY. All outputs are registered except if_stall and dm_stall.
- Eligibility in IDLE: a port is eligible when req=1 and its ack is 0 in that cycle. This blocks re-issue during the cycle the requester is still dropping req.
  - IF is also ineligible when if_abort=1.
- Arbitration in IDLE, evaluated at the clock edge:
  - If DM eligible and not (IF eligible and starve_cnt==IF_STARVE_MAX): go to DM_BUSY. Increment starve_cnt if IF eligible, else clear it.
  - Else if IF eligible: go to IF_BUSY and clear starve_cnt.
  - Else: stay in IDLE.
- Entry into a BUSY state:
  - Latch addr/we/wdata of the granted port into the mem_* registers and set mem_req=1.
  - mem_we=0 for IF.
  - mem_* values are stable for the whole transaction.
- BUSY exit: when mem_ready=1, at the edge:
  - Clear mem_req and go to IDLE.
  - Register mem_rdata into the port's rdata and pulse its ack for exactly 1 cycle.
  - DM write: dm_ack pulses and dm_rdata holds its old value.
- Minimum latency: request seen in IDLE at cycle t → mem_req at t+1 → if mem_ready at t+1, ack at t+2.
  - Back-to-back: a new grant can be taken in the ack cycle by the other port only.
- Abort:
  - if_abort=1 during IF_BUSY sets abort_pend. The memory transaction still completes; on completion if_ack is suppressed, if_rdata is not updated, and abort_pend is cleared.
  - if_abort in the same cycle as mem_ready in IF_BUSY: the ack is suppressed.
  - if_abort has no effect on DM.
- mem_ready outside a BUSY state is ignored.
- starve_cnt saturates at IF_STARVE_MAX and is cleared when IF is granted or if_req=0.
- Requester protocol violations (changing addr or dropping req before ack) are undefined. The bench asserts they never occur.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE=2'd0, IF_BUSY=2'd1, DM_BUSY=2'd2)
  - default widths
  - port-ID constants PORT_IF=1'b0, PORT_DM=1'b1
- One natural sub-module, mem_arb_starve: starvation counter plus grant decision, taking eligibility bits and returning grant and next-count.
- FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Single fetch: if_req=1, if_addr=10'h004, mem_ready one cycle after mem_req, mem_rdata=32'h2008000A → mem_addr=10'h004, mem_we=0; if_ack one cycle with if_rdata=32'h2008000A; exactly one mem_req transaction.
- Simultaneous requests: if_req and dm_req (dm_we=1, dm_addr=10'h010, dm_wdata=32'hDEADBEEF) in the same cycle → DM served first (mem_we=1, mem_wdata=32'hDEADBEEF); dm_rdata unchanged; IF served immediately after; if_stall high throughout.
- Starvation bound: if_req held, dm_req re-asserted every cycle after dm_ack, IF_STARVE_MAX=4 → exactly 4 DM transactions, then the IF transaction, then DM resumes.
- Abort: fetch in IF_BUSY, if_abort pulsed before mem_ready (memory delays 3 cycles) → mem transaction completes; if_ack never asserts; if_rdata keeps its prior value; next arbitration proceeds normally.
- No re-issue: requester drops req one cycle after ack, mem_ready immediate → exactly one mem_req per request; mem_req=0 in the ack cycle when no other port is eligible.
- Reset mid-op: rst=0 asynchronously while DM_BUSY with mem_req=1 → mem_req, dm_ack, dm_rdata, starve_cnt all 0 immediately; after release the first request is granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter between fetch and data-memory stages.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W        = 10;
    localparam int DEF_DATA_W        = 32;
    localparam int DEF_IF_STARVE_MAX = 4;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_starve.sv
// Grant decision for the two requesters plus next value of the IF starvation counter.
// DM is preferred unless IF has already been passed over IF_STARVE_MAX times in a row.
module mem_arb_starve
    import mem_arb_pkg::*;
#(
    parameter int IF_STARVE_MAX = DEF_IF_STARVE_MAX,
    parameter int CNT_W         = 3
) (
    input  logic             if_req,
    input  logic             if_elig,
    input  logic             dm_elig,
    input  logic [CNT_W-1:0] cnt,
    output logic             grant_valid,
    output logic             grant_port,
    output logic [CNT_W-1:0] cnt_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IF_STARVE_MAX);

    logic if_starved_s;

    // Pick the winner and derive the counter value that goes with that choice
    always_comb begin
        if_starved_s = if_elig && (cnt == CNT_MAX);
        grant_valid  = 1'b0;
        grant_port   = PORT_IF;
        cnt_nxt      = cnt;
        if (dm_elig && !if_starved_s) begin
            grant_valid = 1'b1;
            grant_port  = PORT_DM;
            if (!if_elig) begin
                cnt_nxt = {CNT_W{1'b0}};
            end else if (cnt < CNT_MAX) begin
                cnt_nxt = cnt + CNT_W'(1);
            end else begin
                cnt_nxt = cnt;
            end
        end else if (if_elig) begin
            grant_valid = 1'b1;
            grant_port  = PORT_IF;
            cnt_nxt     = {CNT_W{1'b0}};
        end else if (!if_req) begin
            cnt_nxt = {CNT_W{1'b0}};
        end else begin
            cnt_nxt = cnt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences one single-port memory between instruction fetch (read only) and data memory (read/write),
// one transaction outstanding at a time, DM preferred with a bounded wait for IF and fetch abort on flush.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int IF_STARVE_MAX = DEF_IF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_abort,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(IF_STARVE_MAX + 1);

    arb_state_e       state_r;
    logic [CNT_W-1:0] starve_cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             abort_pend_r;
    logic             if_elig_s;
    logic             dm_elig_s;
    logic             grant_valid_s;
    logic             grant_port_s;

    // A port whose ack is up is still dropping its request and must not be re-granted
    always_comb begin
        if_elig_s = if_req && !if_ack && !if_abort;
        dm_elig_s = dm_req && !dm_ack;
    end

    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

    mem_arb_starve #(
        .IF_STARVE_MAX (IF_STARVE_MAX),
        .CNT_W         (CNT_W)
    ) u_starve (
        .if_req      (if_req),
        .if_elig     (if_elig_s),
        .dm_elig     (dm_elig_s),
        .cnt         (starve_cnt_r),
        .grant_valid (grant_valid_s),
        .grant_port  (grant_port_s),
        .cnt_nxt     (cnt_nxt_s)
    );

    // Arbitration FSM with the memory-side and requester-side output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= {DATA_W{1'b0}};
            if_ack       <= 1'b0;
            dm_ack       <= 1'b0;
            if_rdata     <= {DATA_W{1'b0}};
            dm_rdata     <= {DATA_W{1'b0}};
            starve_cnt_r <= {CNT_W{1'b0}};
            abort_pend_r <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state_r)
                IDLE: begin
                    starve_cnt_r <= cnt_nxt_s;
                    if (grant_valid_s && (grant_port_s == PORT_DM)) begin
                        state_r   <= DM_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (grant_valid_s) begin
                        state_r  <= IF_BUSY;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                IF_BUSY: begin
                    if (!if_req) begin
                        starve_cnt_r <= {CNT_W{1'b0}};
                    end
                    // A flush seen at any point of the fetch, including the completion cycle, swallows the result
                    if (mem_ready) begin
                        state_r      <= IDLE;
                        mem_req      <= 1'b0;
                        abort_pend_r <= 1'b0;
                        if (!abort_pend_r && !if_abort) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else if (if_abort) begin
                        abort_pend_r <= 1'b1;
                    end
                end
                DM_BUSY: begin
                    if (!if_req) begin
                        starve_cnt_r <= {CNT_W{1'b0}};
                    end
                    if (mem_ready) begin
                        state_r <= IDLE;
                        mem_req <= 1'b0;
                        dm_ack  <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    mem_req      <= 1'b0;
                    abort_pend_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized requesters and memory,
// all compared every cycle against a transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_abort, if_ack, if_stall;
    logic [9:0]  if_addr;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we, dm_ack, dm_stall;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which port owns the memory (0 none, 1 fetch, 2 data) and what each side should see
    int          owner;
    int          passed_over;
    bit          flushed;
    bit          e_mem_req, e_mem_we, e_if_ack, e_dm_ack;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata, e_if_rdata, e_dm_rdata;

    int dut_txn = 0;
    int dut_if_acks = 0;
    bit prev_mem_req = 1'b0;
    bit if_after = 1'b0, dm_after = 1'b0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
        .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = 0; passed_over = 0; flushed = 1'b0;
        e_mem_req = 1'b0; e_mem_we = 1'b0; e_if_ack = 1'b0; e_dm_ack = 1'b0;
        e_addr = 10'h000; e_wdata = 32'h0; e_if_rdata = 32'h0; e_dm_rdata = 32'h0;
    endtask

    // Advance the model by one clock edge using the inputs presented before that edge
    task automatic model_step();
        bit if_wants, dm_wants, new_if_ack, new_dm_ack;
        if (!rst) begin
            model_reset();
            return;
        end
        new_if_ack = 1'b0;
        new_dm_ack = 1'b0;
        if_wants = if_req && !e_if_ack && !if_abort;
        dm_wants = dm_req && !e_dm_ack;
        if (owner == 0) begin
            if (dm_wants && !(if_wants && passed_over == STARVE)) begin
                owner = 2; e_mem_req = 1'b1; e_mem_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
                passed_over = if_wants ? ((passed_over < STARVE) ? passed_over + 1 : passed_over) : 0;
            end else if (if_wants) begin
                owner = 1; e_mem_req = 1'b1; e_mem_we = 1'b0; e_addr = if_addr; passed_over = 0;
            end else if (!if_req) begin
                passed_over = 0;
            end
        end else begin
            if (!if_req) passed_over = 0;
            if (owner == 1 && mem_ready) begin
                if (!flushed && !if_abort) begin
                    new_if_ack = 1'b1;
                    e_if_rdata = mem_rdata;
                end
                flushed = 1'b0; owner = 0; e_mem_req = 1'b0;
            end else if (owner == 1 && if_abort) begin
                flushed = 1'b1;
            end else if (owner == 2 && mem_ready) begin
                new_dm_ack = 1'b1;
                if (!e_mem_we) e_dm_rdata = mem_rdata;
                owner = 0; e_mem_req = 1'b0;
            end
        end
        e_if_ack = new_if_ack;
        e_dm_ack = new_dm_ack;
    endtask

    task automatic compare_all();
        check_eq("mem_req", mem_req, e_mem_req);
        if (e_mem_req) begin
            check_eq("mem_we", mem_we, e_mem_we);
            check_eq("mem_addr", mem_addr, e_addr);
            if (e_mem_we) check_eq("mem_wdata", mem_wdata, e_wdata);
        end
        check_eq("if_ack", if_ack, e_if_ack);
        check_eq("dm_ack", dm_ack, e_dm_ack);
        check_eq("if_rdata", if_rdata, e_if_rdata);
        check_eq("dm_rdata", dm_rdata, e_dm_rdata);
        check_eq("if_stall", if_stall, if_req & ~e_if_ack);
        check_eq("dm_stall", dm_stall, dm_req & ~e_dm_ack);
        if (mem_req && !prev_mem_req) dut_txn++;
        prev_mem_req = mem_req;
        if (if_ack) dut_if_acks++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int txn0, acks0, dm_acks;
        bit if_done;
        rst = 1'b0; if_req = 1'b0; if_addr = 10'h0; if_abort = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 10'h0; dm_wdata = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        model_reset();
        cycle(); cycle();
        rst = 1'b1;
        cycle();

        // Single fetch with one-cycle memory latency, then no re-issue while req is dropping
        txn0 = dut_txn;
        if_req = 1'b1; if_addr = 10'h004;
        cycle();
        check_eq("fetch_addr", mem_addr, 32'h004);
        check_eq("fetch_we", mem_we, 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'h2008000A;
        cycle();
        check_eq("fetch_ack", if_ack, 32'h1);
        check_eq("fetch_data", if_rdata, 32'h2008000A);
        check_eq("noreissue_ack_cycle", mem_req, 32'h0);
        mem_ready = 1'b0;
        cycle();
        check_eq("noreissue_after", mem_req, 32'h0);
        if_req = 1'b0;
        cycle();
        check_eq("fetch_one_txn", dut_txn - txn0, 32'd1);

        // Abort a fetch while the memory is slow: transaction completes, no ack, data kept
        txn0 = dut_txn; acks0 = dut_if_acks;
        if_req = 1'b1; if_addr = 10'h020;
        cycle();
        if_abort = 1'b1;
        cycle();
        if_abort = 1'b0; if_req = 1'b0;
        cycle(); cycle();
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        cycle();
        mem_ready = 1'b0;
        cycle();
        check_eq("abort_no_ack", dut_if_acks - acks0, 32'd0);
        check_eq("abort_rdata_kept", if_rdata, 32'h2008000A);
        check_eq("abort_one_txn", dut_txn - txn0, 32'd1);
        check_eq("abort_back_idle", mem_req, 32'h0);

        // Simultaneous requests: DM write first, then the waiting fetch back to back
        if_req = 1'b1; if_addr = 10'h040;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h010; dm_wdata = 32'hDEADBEEF;
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        cycle();
        check_eq("simul_dm_first_we", mem_we, 32'h1);
        check_eq("simul_dm_wdata", mem_wdata, 32'hDEADBEEF);
        check_eq("simul_dm_addr", mem_addr, 32'h010);
        check_eq("simul_if_stall_a", if_stall, 32'h1);
        cycle();
        check_eq("simul_dm_ack", dm_ack, 32'h1);
        check_eq("simul_dm_rdata_kept", dm_rdata, 32'h0);
        check_eq("simul_if_stall_b", if_stall, 32'h1);
        cycle();
        dm_req = 1'b0;
        check_eq("simul_if_next_addr", mem_addr, 32'h040);
        check_eq("simul_if_next_req", mem_req, 32'h1);
        check_eq("simul_if_stall_c", if_stall, 32'h1);
        cycle();
        check_eq("simul_if_ack", if_ack, 32'h1);
        check_eq("simul_if_data", if_rdata, 32'hCAFEF00D);
        cycle();
        if_req = 1'b0;
        cycle();

        // Starvation bound: flushes in DM ack cycles keep IF out of the ack-cycle handoff
        if_req = 1'b1; if_addr = 10'h100;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h200; dm_wdata = 32'h0;
        mem_ready = 1'b1;
        dm_acks = 0; if_done = 1'b0; dm_after = 1'b0;
        for (int c = 0; c < 60 && !if_done; c++) begin
            cycle();
            if_abort = 1'b0;
            if (dm_after) begin
                dm_after = 1'b0; dm_addr = dm_addr + 10'd1; dm_wdata = $urandom;
            end
            if (if_ack) if_done = 1'b1;
            else if (dm_ack) begin
                dm_acks++; if_abort = 1'b1; dm_after = 1'b1;
            end
        end
        check_eq("starve_if_served", if_done, 32'h1);
        check_eq("starve_dm_before_if", dm_acks, STARVE);
        cycle();
        if_req = 1'b0;
        cycle();
        check_eq("starve_dm_resumes", dm_ack, 32'h1);
        cycle();
        dm_req = 1'b0;
        mem_ready = 1'b0;
        cycle();

        // Asynchronous reset in the middle of a DM read
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h3FF;
        cycle();
        check_eq("rstmid_busy", mem_req, 32'h1);
        #2 rst = 1'b0;
        #1;
        check_eq("rstmid_mem_req", mem_req, 32'h0);
        check_eq("rstmid_dm_ack", dm_ack, 32'h0);
        check_eq("rstmid_dm_rdata", dm_rdata, 32'h0);
        check_eq("rstmid_if_rdata", if_rdata, 32'h0);
        model_reset();
        dm_req = 1'b0;
        cycle();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 10'h0AB;
        cycle();
        check_eq("rstmid_regrant_req", mem_req, 32'h1);
        check_eq("rstmid_regrant_addr", mem_addr, 32'h0AB);
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        cycle();
        mem_ready = 1'b0;
        cycle();
        if_req = 1'b0;
        cycle();

        // Randomized requesters and memory, checked every cycle against the model
        if_after = 1'b0; dm_after = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            cycle();
            if_abort = 1'b0;
            if (if_after) begin
                if_after = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    if_req = 1'b1; if_addr = 10'($urandom);
                end else begin
                    if_req = 1'b0;
                end
            end else if (if_ack) begin
                if_after = 1'b1;
            end else if (if_req && $urandom_range(0, 11) == 0) begin
                if_abort = 1'b1; if_after = 1'b1;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = 10'($urandom);
            end
            if (dm_after) begin
                dm_after = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    dm_req = 1'b1; dm_we = 1'($urandom); dm_addr = 10'($urandom); dm_wdata = $urandom;
                end else begin
                    dm_req = 1'b0;
                end
            end else if (dm_ack) begin
                dm_after = 1'b1;
            end else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_we = 1'($urandom); dm_addr = 10'($urandom); dm_wdata = $urandom;
            end
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
